// File: rtl/fetch_engine.sv
// Fetch stage: fetches a FETCH_WIDTH-instruction bundle per cycle, predicts branches
// with a small fully-associative BTB, and buffers bundles in a queue toward decode.
module fetch_engine #(
  parameter int                FETCH_WIDTH = 2,
  parameter int                QDEPTH      = 8,
  parameter int                BTB_ENTRIES = 4,
  parameter int                ADDR_W      = 16,
  parameter int                INSTR_W     = 16,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           redirect,
  input  logic [ADDR_W-1:0]              redirect_pc,
  output logic [ADDR_W-1:0]              imem_addr,
  input  logic [FETCH_WIDTH*INSTR_W-1:0] imem_rdata,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [FETCH_WIDTH*INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]              out_pc,
  output logic [FETCH_WIDTH-1:0]         out_slot_valid,
  output logic [FETCH_WIDTH-1:0]         out_pred_taken,
  input  logic                           bp_upd_valid,
  input  logic [ADDR_W-1:0]              bp_upd_pc,
  input  logic                           bp_upd_taken,
  input  logic [ADDR_W-1:0]              bp_upd_target,
  output logic [$clog2(QDEPTH):0]        q_count
);

  localparam int QW = $clog2(QDEPTH);
  localparam int BW = (BTB_ENTRIES > 1) ? $clog2(BTB_ENTRIES) : 1;
  localparam int DW = FETCH_WIDTH * INSTR_W;

  logic [ADDR_W-1:0]      pc_q;
  logic [DW-1:0]          qi_q [QDEPTH];
  logic [ADDR_W-1:0]      qp_q [QDEPTH];
  logic [FETCH_WIDTH-1:0] qs_q [QDEPTH];
  logic [FETCH_WIDTH-1:0] qt_q [QDEPTH];
  logic [QW-1:0]          wr_q, rd_q, rd_d;
  logic [QW:0]            cnt_q, cnt_d;

  logic                   hv_q, hv_d;
  logic [DW-1:0]          hi_q, hi_d;
  logic [ADDR_W-1:0]      hp_q, hp_d;
  logic [FETCH_WIDTH-1:0] hs_q, hs_d;
  logic [FETCH_WIDTH-1:0] ht_q, ht_d;

  logic [BTB_ENTRIES-1:0] bv_q;
  logic [ADDR_W-1:0]      btag_q [BTB_ENTRIES];
  logic [ADDR_W-1:0]      btgt_q [BTB_ENTRIES];
  logic [1:0]             bctr_q [BTB_ENTRIES];
  logic [BW-1:0]          victim_q;

  logic [ADDR_W-1:0]      slot_pc_s  [FETCH_WIDTH];
  logic [ADDR_W-1:0]      slot_tgt_s [FETCH_WIDTH];
  logic [FETCH_WIDTH-1:0] taken_s, sv_s, pt_s;
  logic [ADDR_W-1:0]      next_pc_s;
  logic                   found_s;
  logic                   fetch_s, pop_s;

  logic                   upd_hit_s, free_s;
  logic [BW-1:0]          upd_idx_s, free_idx_s, alloc_idx_s;

  assign imem_addr      = pc_q;
  assign out_valid      = hv_q;
  assign out_instr      = hi_q;
  assign out_pc         = hp_q;
  assign out_slot_valid = hs_q;
  assign out_pred_taken = ht_q;
  assign q_count        = cnt_q;

  // Tags are unique, so at most one entry matches a slot and OR-merging is exact.
  always_comb begin
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      slot_pc_s[i]  = pc_q + ADDR_W'(2 * i);
      slot_tgt_s[i] = '0;
      taken_s[i]    = 1'b0;
      for (int e = 0; e < BTB_ENTRIES; e++) begin
        taken_s[i]    = taken_s[i] | (bv_q[e] && (btag_q[e] == slot_pc_s[i]) && bctr_q[e][1]);
        slot_tgt_s[i] = slot_tgt_s[i] |
                        ((bv_q[e] && (btag_q[e] == slot_pc_s[i])) ? btgt_q[e] : '0);
      end
    end
  end

  always_comb begin
    sv_s      = '0;
    pt_s      = '0;
    found_s   = 1'b0;
    next_pc_s = pc_q + ADDR_W'(2 * FETCH_WIDTH);
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      sv_s[i] = !found_s;
      if (!found_s && taken_s[i]) begin
        pt_s[i]   = 1'b1;
        next_pc_s = slot_tgt_s[i];
        found_s   = 1'b1;
      end else begin
        pt_s[i] = 1'b0;
      end
    end
  end

  assign fetch_s = !redirect && (cnt_q < (QW+1)'(QDEPTH));
  assign pop_s   = hv_q && out_ready && !redirect;
  assign cnt_d   = cnt_q + (QW+1)'(fetch_s) - (QW+1)'(pop_s);
  assign rd_d    = rd_q + QW'(pop_s);

  // Next head: a bundle pushed into the slot that becomes the head is forwarded from the push.
  always_comb begin
    hv_d = (cnt_d != '0);
    if (cnt_d == '0) begin
      hi_d = '0;
      hp_d = '0;
      hs_d = '0;
      ht_d = '0;
    end else if (fetch_s && (wr_q == rd_d)) begin
      hi_d = imem_rdata;
      hp_d = pc_q;
      hs_d = sv_s;
      ht_d = pt_s;
    end else begin
      hi_d = qi_q[rd_d];
      hp_d = qp_q[rd_d];
      hs_d = qs_q[rd_d];
      ht_d = qt_q[rd_d];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q  <= RESET_PC;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      hv_q  <= 1'b0;
      hi_q  <= '0;
      hp_q  <= '0;
      hs_q  <= '0;
      ht_q  <= '0;
    end else if (redirect) begin
      pc_q  <= redirect_pc;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      hv_q  <= 1'b0;
      hi_q  <= '0;
      hp_q  <= '0;
      hs_q  <= '0;
      ht_q  <= '0;
    end else begin
      if (fetch_s) begin
        pc_q <= next_pc_s;
        wr_q <= wr_q + QW'(1);
      end
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      hv_q  <= hv_d;
      hi_q  <= hi_d;
      hp_q  <= hp_d;
      hs_q  <= hs_d;
      ht_q  <= ht_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && fetch_s) begin
      qi_q[wr_q] <= imem_rdata;
      qp_q[wr_q] <= pc_q;
      qs_q[wr_q] <= sv_s;
      qt_q[wr_q] <= pt_s;
    end
  end

  // Descending scan so the lowest-index invalid entry wins allocation.
  always_comb begin
    upd_hit_s  = 1'b0;
    upd_idx_s  = '0;
    free_s     = 1'b0;
    free_idx_s = '0;
    for (int e = BTB_ENTRIES - 1; e >= 0; e--) begin
      upd_hit_s  = upd_hit_s | (bv_q[e] && (btag_q[e] == bp_upd_pc));
      upd_idx_s  = (bv_q[e] && (btag_q[e] == bp_upd_pc)) ? BW'(e) : upd_idx_s;
      free_s     = free_s | !bv_q[e];
      free_idx_s = !bv_q[e] ? BW'(e) : free_idx_s;
    end
    alloc_idx_s = free_s ? free_idx_s : victim_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      bv_q     <= '0;
      victim_q <= '0;
      for (int e = 0; e < BTB_ENTRIES; e++) begin
        btag_q[e] <= '0;
        btgt_q[e] <= '0;
        bctr_q[e] <= 2'd0;
      end
    end else if (bp_upd_valid) begin
      if (upd_hit_s) begin
        if (bp_upd_taken) begin
          bctr_q[upd_idx_s] <= (bctr_q[upd_idx_s] == 2'd3) ? 2'd3 : bctr_q[upd_idx_s] + 2'd1;
          btgt_q[upd_idx_s] <= bp_upd_target;
        end else begin
          bctr_q[upd_idx_s] <= (bctr_q[upd_idx_s] == 2'd0) ? 2'd0 : bctr_q[upd_idx_s] - 2'd1;
        end
      end else if (bp_upd_taken) begin
        bv_q[alloc_idx_s]   <= 1'b1;
        btag_q[alloc_idx_s] <= bp_upd_pc;
        btgt_q[alloc_idx_s] <= bp_upd_target;
        bctr_q[alloc_idx_s] <= 2'd2;
        if (!free_s) begin
          victim_q <= (victim_q == BW'(BTB_ENTRIES - 1)) ? '0 : victim_q + BW'(1);
        end
      end
    end
  end

endmodule

// File: doc/fetch_engine.md
Name: fetch_engine

Overview:
- Parametrised successor of the dual-issue fetch stage.
- Fetches FETCH_WIDTH instructions per cycle from an external combinational instruction-memory port.
- Predicts branches with a fully-associative BTB holding 2-bit saturating counters.
- Buffers fetched bundles in a QDEPTH-entry queue, which decouples fetch from decode through a valid/ready handshake. Sits between instruction memory and decode; redirects come from execute/commit.

Parameters:
- FETCH_WIDTH, 2: instructions per bundle (1..4).
- QDEPTH, 8: fetch-queue depth in bundles (power of 2, >=2).
- BTB_ENTRIES, 4: BTB entries (>=1).
- ADDR_W, 16: PC width.
- INSTR_W, 16: instruction width; PC step per slot is 2.
- RESET_PC, 0: PC value loaded at reset.

Ports:
- clk  in  1  clock; all state changes on posedge.
- reset  in  1  synchronous, active-low reset.
- redirect  in  1  external PC write; flushes the queue.
- redirect_pc  in  ADDR_W  new PC when redirect=1.
- imem_addr  out  ADDR_W  fetch address, equal to the PC register.
- imem_rdata  in  FETCH_WIDTH*INSTR_W  slot i occupies bits [i*INSTR_W +: INSTR_W]; valid in the same cycle as imem_addr.
- out_valid  out  1  queue head is valid.
- out_ready  in  1  decode accepts the head.
- out_instr  out  FETCH_WIDTH*INSTR_W  head bundle instructions.
- out_pc  out  ADDR_W  head bundle base PC; slot i PC = out_pc + 2*i.
- out_slot_valid  out  FETCH_WIDTH  bit i = slot i valid.
- out_pred_taken  out  FETCH_WIDTH  bit i = slot i predicted taken.
- bp_upd_valid  in  1  BTB update strobe.
- bp_upd_pc  in  ADDR_W  resolved branch PC.
- bp_upd_taken  in  1  resolved direction.
- bp_upd_target  in  ADDR_W  resolved target.
- q_count  out  clog2(QDEPTH)+1  bundles held in the queue.

Behaviour:
- Reset (reset=0 at a posedge):
  - PC <= RESET_PC.
  - Queue emptied; q_count=0, out_valid=0.
  - All BTB entries invalid; victim pointer = 0.
  - Output payload fields read 0.
- Priority, highest first: reset, redirect, normal operation.
- Fetch enable: fetch when !redirect && q_count < QDEPTH. A pop in the same cycle does not permit a push into a full queue.
- BTB lookup (combinational on the PC):
  - hit_i = a valid entry with tag == PC + 2*i.
  - taken_i = hit_i && counter[1].
  - j = the lowest slot with taken_i.
- Bundle formation:
  - With a taken slot j: slot_valid = slots 0..j; pred_taken = bit j only; next PC = target of slot j.
  - With no taken slot: all slots valid; pred_taken = 0; next PC = PC + 2*FETCH_WIDTH.
  - All PC arithmetic wraps modulo 2^ADDR_W.
- On a fetch: push {imem_rdata, PC, slot_valid, pred_taken} at the tail and load the next PC. No fetch means the PC holds.
- Latency: a bundle pushed at edge k is visible on out_* after edge k. No bypass from memory to output.
- Pop: out_valid && out_ready at a posedge advances the head.
  - Push and pop together leave q_count unchanged.
  - Pointers wrap modulo QDEPTH.
  - Output fields are stable while out_valid && !out_ready.
- Redirect: on the posedge, PC <= redirect_pc, queue flushed (q_count=0), no push, and any pop is ignored. out_valid=0 in the following cycle; the next fetch uses redirect_pc.
- BTB update (independent of redirect and queue state; applied at the posedge):
  - Tag hit: counter saturating +1 if taken, else saturating -1 (range 0..3). Target <= bp_upd_target only if taken. The entry stays valid.
  - Miss and taken: allocate the lowest-index invalid entry. If none is invalid, replace the entry at the victim pointer, then victim pointer +1 mod BTB_ENTRIES. New entry: tag=bp_upd_pc, target=bp_upd_target, counter=2.
  - Miss and not taken: no change.
  - Tags are unique by construction.
  - A lookup in the same cycle as an update sees the pre-update state.
- Reset mid-operation discards queue and BTB contents identically to power-up reset.

Test Plan:
- Reset then release, out_ready=1, empty BTB, imem returns addr-tagged data: bundles emitted with out_pc 0x0000, 0x0004, 0x0008…; slot_valid=2'b11; pred_taken=0; the first out_valid follows the first post-reset edge.
- out_ready=0 from reset: after 8 fetch edges q_count=8 and imem_addr holds 0x0020; raise out_ready for 1 cycle -> q_count=7, then the next edge pushes pc 0x0020.
- Update pc=0x0006, taken, target 0x0040; fetch at 0x0004 -> slot_valid=11, pred_taken=10, next imem_addr=0x0040. Repeat with branch pc=0x0004 -> slot_valid=01, pred_taken=01.
- Two not-taken updates to pc 0x0006 (counter 2->1->0) -> fetch at 0x0004 gives pred_taken=00 and next PC 0x0008. A taken update then raises the counter to 1, so the prediction is still not taken.
- Queue holds 5 bundles with out_ready=1; assert redirect to 0x0100 -> next cycle q_count=0 and out_valid=0; following bundle out_pc=0x0100.
- BTB_ENTRIES=4: taken updates at 0x10, 0x20, 0x30, 0x40, 0x50 -> 0x50 replaces entry 0 and the victim pointer becomes 1. A lookup at 0x10 misses; 0x20 still hits.
